servo_pulse_gen: RTL and testbench
==================================

SERVO_PULSE_GEN -- requirements
Module: servo_pulse_gen

Interface
REQ-001 SHALL have parameter SYS_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter PWM_FREQ, default 50, frame rate in Hz (20 ms servo frame).
REQ-003 SHALL have parameter STEPS, default 1000, duty resolution in steps per frame (per-mille).
REQ-004 SHALL have parameter DUTY_RST, default 75, active duty after reset (1.5 ms, servo neutral).
REQ-005 SHALL have parameters DUTY_MIN (default 25) and DUTY_MAX (default 125), the clamp bounds.
REQ-006 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port rstp  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port en  input  1  generator enable; low holds the output low.
REQ-009 SHALL have port duty_in  input  10  requested duty in steps.
REQ-010 SHALL have port duty_load  input  1  single-cycle strobe that captures duty_in.
REQ-011 SHALL have port pwm_out  output  1  registered servo pulse.
REQ-012 SHALL have port frame_start  output  1  single-cycle pulse on the first cycle of each frame.
REQ-013 SHALL have port duty_active  output  10  duty currently being generated.
REQ-014 SHALL have port pending  output  1  high while a captured duty awaits the next frame boundary.

Function
REQ-015 Prescaler SHALL count 0..PRE-1, where PRE = SYS_FREQ/(PWM_FREQ*STEPS) (integer division), and SHALL assert an internal tick for one cycle at PRE-1 before wrapping to 0.
REQ-016 Step counter SHALL advance by 1 on each tick and wrap from STEPS-1 to 0; that wrapping tick is the frame boundary.
REQ-017 pwm_out SHALL be registered as (en && step_cnt < duty_active), lagging the counters by exactly one clock.
REQ-018 duty_active = 0 SHALL give a constant-low output; duty_active >= STEPS SHALL give a constant-high output while en is high.
REQ-019 duty_load SHALL capture duty_in into a shadow register and set pending; a later load before the boundary SHALL overwrite the shadow value (last load wins).
REQ-020 At the frame boundary, if pending is set, duty_active SHALL take the shadow value and pending SHALL clear in the same cycle.
REQ-021 duty_load coincident with the boundary cycle SHALL transfer that cycle's duty_in directly into duty_active and leave pending clear.
REQ-022 duty_active SHALL NOT change at any point other than the frame boundary, so no pulse is truncated or stretched mid-frame.
REQ-023 frame_start SHALL be registered and SHALL pulse for one cycle, asserted the cycle after the boundary tick.
REQ-024 While en is low, the prescaler and step counter SHALL be held at 0, pwm_out SHALL be 0, and frame_start SHALL be 0; duty_load SHALL still be accepted.
REQ-025 The first cycle with en high after en was low SHALL be treated as a frame boundary: any pending value transfers and frame_start pulses on the next cycle.

Reset
REQ-026 On rstp high, asynchronously: pwm_out=0, frame_start=0, pending=0, shadow=DUTY_RST, duty_active=DUTY_RST, prescaler=0, step counter=0.
REQ-027 Assertion of rstp mid-frame SHALL abort the frame immediately; after release, the first frame SHALL start from step 0.

Configuration
REQ-028 When macro SERVO_DUTY_CLAMP_EN is defined, duty_in SHALL be clamped to [DUTY_MIN, DUTY_MAX] at capture, so duty_active never leaves that range.
REQ-029 When SERVO_DUTY_CLAMP_EN is undefined, duty_in SHALL be captured unmodified, with full 0..1023 range; REQ-018 governs the extremes.

Verification (SYS_FREQ=50_000, PWM_FREQ=50, STEPS=1000, so PRE=1)
REQ-030 Reset released, en=1, no load -> pwm_out high for exactly 75 cycles per 1000-cycle frame; frame_start every 1000 cycles; duty_active=75.
REQ-031 duty_load with duty_in=125 at step 40 -> pending=1; current frame stays 75 high; next frame 125 high; pending clears at boundary.
REQ-032 Loads of 30 then 110 within one frame; separately, a load of 100 on the boundary cycle -> next frame uses 110; in the boundary case, 100 applies immediately and pending stays 0.
REQ-033 Clamp enabled: load 5 -> 25 cycles high; load 900 -> 125 high. Clamp disabled: load 0 -> constant low; load 1000 -> constant high.
REQ-034 en dropped at step 30 -> pwm_out low next cycle, counters at 0; load 50 while en low; en raised -> frame_start next cycle, 50 high cycles.
REQ-035 rstp pulsed at step 60 of a duty-100 frame -> outputs at reset values immediately; after release, duty 75 frames from step 0.

Source files
------------

// File: rtl/servo_pulse_gen.sv
// servo_pulse_gen
//   Frame-based servo PWM generator. A prescaler divides clk down to the step
//   rate, and a step counter runs 0..STEPS-1 once per frame. pwm_out is high
//   while the step count is below the active duty. New duty values are
//   captured into a shadow register and only take effect at a frame boundary,
//   so a pulse is never cut short or stretched part-way through a frame.
//
//   Optional build macro: SERVO_DUTY_CLAMP_EN
//     defined   -> duty_in is clamped to [DUTY_MIN, DUTY_MAX] when captured
//     undefined -> duty_in is captured unmodified (0..1023)
//
// Ports
//   clk          in   system clock, rising edge
//   rstp         in   asynchronous active-high reset
//   en           in   generator enable; low holds counters and output at 0
//   duty_in      in   [9:0] requested duty in steps
//   duty_load    in   single-cycle strobe that captures duty_in
//   pwm_out      out  registered servo pulse
//   frame_start  out  one-cycle pulse on the first cycle of each frame
//   duty_active  out  [9:0] duty currently being generated
//   pending      out  captured duty waiting for the next frame boundary
module servo_pulse_gen #(
  parameter int SYS_FREQ = 125_000_000,
  parameter int PWM_FREQ = 50,
  parameter int STEPS    = 1000,
  parameter int DUTY_RST = 75,
  parameter int DUTY_MIN = 25,
  parameter int DUTY_MAX = 125
) (
  input  logic       clk,
  input  logic       rstp,
  input  logic       en,
  input  logic [9:0] duty_in,
  input  logic       duty_load,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [9:0] duty_active,
  output logic       pending
);

  localparam int PRE    = SYS_FREQ / (PWM_FREQ * STEPS);
  localparam int PRE_N  = (PRE < 1) ? 1 : PRE;
  localparam int PRE_W  = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CMP_W  = (STEP_W > 10) ? STEP_W : 10;

  logic [PRE_W-1:0]  pre_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [9:0]        shadow;
  logic [9:0]        duty_cap;
  logic              en_q;
  logic              run;
  logic              tick;
  logic              wrap;
  logic              boundary;

  // Counters only run once en has been high for a full cycle. The first
  // enabled cycle is a restart: it acts as the boundary (duty transfer,
  // frame_start next cycle) while the counters stay parked at 0, so the
  // following cycle is step 0 of a clean frame.
  assign run      = en & en_q;
  assign tick     = (pre_cnt == PRE_W'(PRE_N - 1));
  assign wrap     = tick & (step_cnt == STEP_W'(STEPS - 1));
  assign boundary = en & (~en_q | wrap);

  always_comb begin
    duty_cap = duty_in;
`ifdef SERVO_DUTY_CLAMP_EN
    if (duty_in < 10'(DUTY_MIN)) begin
      duty_cap = 10'(DUTY_MIN);
    end else if (duty_in > 10'(DUTY_MAX)) begin
      duty_cap = 10'(DUTY_MAX);
    end
`endif
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      en_q     <= 1'b0;
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      en_q <= en;
      if (!run) begin
        pre_cnt  <= '0;
        step_cnt <= '0;
      end else if (tick) begin
        pre_cnt  <= '0;
        step_cnt <= wrap ? '0 : step_cnt + STEP_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pwm_out     <= run & (CMP_W'(step_cnt) < CMP_W'(duty_active));
      frame_start <= boundary;
    end
  end

  // A load landing on the boundary cycle bypasses the shadow hand-off and
  // goes straight to duty_active; otherwise the last load before the
  // boundary is the one that gets transferred.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      shadow      <= 10'(DUTY_RST);
      duty_active <= 10'(DUTY_RST);
      pending     <= 1'b0;
    end else if (boundary && duty_load) begin
      shadow      <= duty_cap;
      duty_active <= duty_cap;
      pending     <= 1'b0;
    end else if (boundary && pending) begin
      duty_active <= shadow;
      pending     <= 1'b0;
    end else if (duty_load) begin
      shadow  <= duty_cap;
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_pulse_gen.sv
// tb_servo_pulse_gen
//   Directed bench for servo_pulse_gen with PRE=1 (one step per clock,
//   1000-cycle frames). Outputs are sampled 1 ns after each rising edge and
//   inputs are changed at the same point.
module tb_servo_pulse_gen;

  logic       clk = 1'b0;
  logic       rstp;
  logic       en;
  logic [9:0] duty_in;
  logic       duty_load;
  logic       pwm_out;
  logic       frame_start;
  logic [9:0] duty_active;
  logic       pending;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  servo_pulse_gen #(
    .SYS_FREQ (50_000),
    .PWM_FREQ (50),
    .STEPS    (1000),
    .DUTY_RST (75),
    .DUTY_MIN (25),
    .DUTY_MAX (125)
  ) dut (
    .clk         (clk),
    .rstp        (rstp),
    .en          (en),
    .duty_in     (duty_in),
    .duty_load   (duty_load),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .duty_active (duty_active),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input int limit, input string name);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < limit) begin
      step_cyc();
      n++;
    end
    vec_cnt++;
    if (frame_start !== 1'b1) begin
      miss_cnt++;
      $display("FAIL %s: frame_start not seen within %0d cycles", name, limit);
    end
  endtask

  // Called on a frame_start sample (step 0). Samples k=1..1000 cover the
  // pwm results of steps 0..999; sample 1000 is the next frame_start.
  // Loads are driven in the cycle whose sample index matches; k=999 is the
  // boundary cycle.
  task automatic run_frame(input int la_k, input logic [9:0] la_v,
                           input int lb_k, input logic [9:0] lb_v,
                           output int highs, output int fs_bad,
                           output logic pend_mid, output logic [9:0] duty_mid,
                           output logic pend_end, output logic [9:0] duty_end);
    highs  = 0;
    fs_bad = 0;
    pend_mid = 1'bx;
    duty_mid = 'x;
    for (int k = 1; k <= 1000; k++) begin
      step_cyc();
      if (pwm_out === 1'b1) highs++;
      if (k < 1000 && frame_start !== 1'b0) fs_bad++;
      if (k == 1000 && frame_start !== 1'b1) fs_bad++;
      if (k == 999) begin
        pend_mid = pending;
        duty_mid = duty_active;
      end
      duty_load = 1'b0;
      if (k == la_k) begin
        duty_load = 1'b1;
        duty_in   = la_v;
      end else if (k == lb_k) begin
        duty_load = 1'b1;
        duty_in   = lb_v;
      end
    end
    pend_end = pending;
    duty_end = duty_active;
  endtask

  int         hi;
  int         fsb;
  logic       pm;
  logic       pe;
  logic [9:0] dm;
  logic [9:0] de;

  task automatic test_reset();
    rstp = 1'b1; en = 1'b0; duty_load = 1'b0; duty_in = '0;
    repeat (3) step_cyc();
    vec_cnt++; if (pwm_out !== 1'b0) begin miss_cnt++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    vec_cnt++; if (frame_start !== 1'b0) begin miss_cnt++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    vec_cnt++; if (pending !== 1'b0) begin miss_cnt++; $display("FAIL rst_pending: got %b want 0", pending); end
    vec_cnt++; if (duty_active !== 10'd75) begin miss_cnt++; $display("FAIL rst_duty: got %0d want 75", duty_active); end
  endtask

  task automatic test_default_frame();
    en = 1'b1;
    rstp = 1'b0;
    wait_fs(5, "start_fs");
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
      vec_cnt++; if (hi !== 75) begin miss_cnt++; $display("FAIL def_highs[%0d]: got %0d want 75", f, hi); end
      vec_cnt++; if (fsb !== 0) begin miss_cnt++; $display("FAIL def_fs_period[%0d]: got %0d bad samples want 0", f, fsb); end
      vec_cnt++; if (de !== 10'd75) begin miss_cnt++; $display("FAIL def_duty[%0d]: got %0d want 75", f, de); end
      vec_cnt++; if (pe !== 1'b0) begin miss_cnt++; $display("FAIL def_pending[%0d]: got %b want 0", f, pe); end
    end
  endtask

  task automatic test_pending();
    run_frame(40, 10'd125, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 75) begin miss_cnt++; $display("FAIL pend_cur_highs: got %0d want 75", hi); end
    vec_cnt++; if (pm !== 1'b1) begin miss_cnt++; $display("FAIL pend_set: got %b want 1", pm); end
    vec_cnt++; if (dm !== 10'd75) begin miss_cnt++; $display("FAIL pend_duty_mid: got %0d want 75", dm); end
    vec_cnt++; if (pe !== 1'b0) begin miss_cnt++; $display("FAIL pend_clear: got %b want 0", pe); end
    vec_cnt++; if (de !== 10'd125) begin miss_cnt++; $display("FAIL pend_duty_new: got %0d want 125", de); end
    run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 125) begin miss_cnt++; $display("FAIL pend_next_highs: got %0d want 125", hi); end
  endtask

  task automatic test_last_wins();
    run_frame(100, 10'd30, 200, 10'd110, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 125) begin miss_cnt++; $display("FAIL lw_cur_highs: got %0d want 125", hi); end
    vec_cnt++; if (dm !== 10'd125) begin miss_cnt++; $display("FAIL lw_duty_mid: got %0d want 125", dm); end
    vec_cnt++; if (de !== 10'd110) begin miss_cnt++; $display("FAIL lw_duty_new: got %0d want 110", de); end
    run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 110) begin miss_cnt++; $display("FAIL lw_next_highs: got %0d want 110", hi); end
  endtask

  task automatic test_boundary_load();
    run_frame(999, 10'd100, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 110) begin miss_cnt++; $display("FAIL bl_cur_highs: got %0d want 110", hi); end
    vec_cnt++; if (pm !== 1'b0) begin miss_cnt++; $display("FAIL bl_pend_before: got %b want 0", pm); end
    vec_cnt++; if (pe !== 1'b0) begin miss_cnt++; $display("FAIL bl_pend_after: got %b want 0", pe); end
    vec_cnt++; if (de !== 10'd100) begin miss_cnt++; $display("FAIL bl_duty: got %0d want 100", de); end
    run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 100) begin miss_cnt++; $display("FAIL bl_next_highs: got %0d want 100", hi); end
  endtask

  task automatic test_extremes();
`ifdef SERVO_DUTY_CLAMP_EN
    run_frame(500, 10'd5, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (de !== 10'd25) begin miss_cnt++; $display("FAIL clamp_lo_duty: got %0d want 25", de); end
    run_frame(500, 10'd900, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 25) begin miss_cnt++; $display("FAIL clamp_lo_highs: got %0d want 25", hi); end
    vec_cnt++; if (de !== 10'd125) begin miss_cnt++; $display("FAIL clamp_hi_duty: got %0d want 125", de); end
    run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 125) begin miss_cnt++; $display("FAIL clamp_hi_highs: got %0d want 125", hi); end
`else
    run_frame(500, 10'd0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (de !== 10'd0) begin miss_cnt++; $display("FAIL zero_duty: got %0d want 0", de); end
    run_frame(500, 10'd1000, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 0) begin miss_cnt++; $display("FAIL zero_highs: got %0d want 0", hi); end
    vec_cnt++; if (de !== 10'd1000) begin miss_cnt++; $display("FAIL full_duty: got %0d want 1000", de); end
    run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 1000) begin miss_cnt++; $display("FAIL full_highs: got %0d want 1000", hi); end
`endif
  endtask

  task automatic test_enable();
    logic [9:0] d_prev;
    int         pwm_hi;
    int         fs_hi;
`ifdef SERVO_DUTY_CLAMP_EN
    d_prev = 10'd125;
`else
    d_prev = 10'd1000;
`endif
    for (int k = 1; k <= 30; k++) step_cyc();
    en = 1'b0;
    step_cyc();
    vec_cnt++; if (pwm_out !== 1'b0) begin miss_cnt++; $display("FAIL en_low_pwm: got %b want 0", pwm_out); end
    vec_cnt++; if (frame_start !== 1'b0) begin miss_cnt++; $display("FAIL en_low_fs: got %b want 0", frame_start); end
    duty_load = 1'b1; duty_in = 10'd50;
    step_cyc();
    duty_load = 1'b0;
    step_cyc();
    vec_cnt++; if (pending !== 1'b1) begin miss_cnt++; $display("FAIL en_low_pending: got %b want 1", pending); end
    vec_cnt++; if (duty_active !== d_prev) begin miss_cnt++; $display("FAIL en_low_duty: got %0d want %0d", duty_active, d_prev); end
    pwm_hi = 0; fs_hi = 0;
    for (int k = 0; k < 20; k++) begin
      step_cyc();
      if (pwm_out !== 1'b0) pwm_hi++;
      if (frame_start !== 1'b0) fs_hi++;
    end
    vec_cnt++; if (pwm_hi !== 0 || fs_hi !== 0) begin miss_cnt++; $display("FAIL en_low_hold: pwm %0d fs %0d want 0 0", pwm_hi, fs_hi); end
    en = 1'b1;
    step_cyc();
    vec_cnt++; if (frame_start !== 1'b1) begin miss_cnt++; $display("FAIL en_rise_fs: got %b want 1", frame_start); end
    vec_cnt++; if (duty_active !== 10'd50 || pending !== 1'b0) begin miss_cnt++; $display("FAIL en_rise_xfer: duty %0d pending %b want 50 0", duty_active, pending); end
    run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 50) begin miss_cnt++; $display("FAIL en_rise_highs: got %0d want 50", hi); end
    vec_cnt++; if (fsb !== 0) begin miss_cnt++; $display("FAIL en_rise_period: got %0d bad samples want 0", fsb); end
  endtask

  task automatic test_reset_mid();
    run_frame(10, 10'd100, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (de !== 10'd100) begin miss_cnt++; $display("FAIL rm_setup_duty: got %0d want 100", de); end
    for (int k = 1; k <= 60; k++) begin
      step_cyc();
      duty_load = (k == 10);
      duty_in   = 10'd200;
    end
    duty_load = 1'b0;
    vec_cnt++; if (pwm_out !== 1'b1 || pending !== 1'b1) begin miss_cnt++; $display("FAIL rm_before: pwm %b pending %b want 1 1", pwm_out, pending); end
    rstp = 1'b1;
    #1;
    vec_cnt++; if (pwm_out !== 1'b0 || frame_start !== 1'b0) begin miss_cnt++; $display("FAIL rm_async_out: pwm %b fs %b want 0 0", pwm_out, frame_start); end
    vec_cnt++; if (pending !== 1'b0 || duty_active !== 10'd75) begin miss_cnt++; $display("FAIL rm_async_duty: pending %b duty %0d want 0 75", pending, duty_active); end
    repeat (2) step_cyc();
    rstp = 1'b0;
    wait_fs(5, "rm_restart_fs");
    run_frame(-1, '0, -1, '0, hi, fsb, pm, dm, pe, de);
    vec_cnt++; if (hi !== 75) begin miss_cnt++; $display("FAIL rm_highs: got %0d want 75", hi); end
    vec_cnt++; if (fsb !== 0) begin miss_cnt++; $display("FAIL rm_period: got %0d bad samples want 0", fsb); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_pending();
    test_last_wins();
    test_boundary_load();
    test_extremes();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
